// File: rtl/chan_regf_pkg.sv
// Shared register-map constants and types for the chan_regf channel register file.
package chan_regf_pkg;

   localparam int CTRL_ENA_B    = 0;
   localparam int CTRL_IRQ_EN_B = 1;
   localparam int CTRL_MODE_LSB = 4;
   localparam int MODE_MAX_W    = 8;

   localparam int STAT_BUSY_B   = 0;
   localparam int STAT_DONE_B   = 1;
   localparam int STAT_OVF_B    = 2;

   // Mode is stored at its widest legal size; channels only drive the low MODE_W bits.
   typedef struct packed {
      logic [MODE_MAX_W-1:0] mode;
      logic                  irq_en;
      logic                  ena;
   } ctrl_t;

   function automatic logic [31:0] word_addr(input int unsigned ch, input logic is_stat);
      return (ch << 1) | {31'd0, is_stat};
   endfunction

endpackage

// File: rtl/chan_regf_ch.sv
// One channel: control word, sticky done/overflow flags and the channel's irq term.
module chan_regf_ch
   import chan_regf_pkg::*;
#(
   parameter int MODE_W = 3
) (
   input  logic              main_clk_i,
   input  logic              main_rst_i,
   input  logic              soft_rst_i,
   input  logic              ctrl_we,
   input  logic              stat_we,
   input  logic [31:0]       wdata,
   input  logic              busy,
   input  logic              done_ev,
   output logic              ena,
   output logic [MODE_W-1:0] mode,
   output logic              irq_term,
   output logic [31:0]       ctrl_rd,
   output logic [31:0]       stat_rd
);

   ctrl_t ctrl_q;
   logic  done_q, ovf_q;
   logic  done_clr, ovf_clr, ovf_set;
   logic  unused_wdata;

   assign done_clr = stat_we & wdata[STAT_DONE_B];
   assign ovf_clr  = stat_we & wdata[STAT_OVF_B];
   // A new event on an already-set flag overflows, unless software is clearing it this cycle.
   assign ovf_set  = done_ev & done_q & ~done_clr;

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i || soft_rst_i) begin
         ctrl_q <= '0;
         done_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (ctrl_we) begin
            ctrl_q.ena    <= wdata[CTRL_ENA_B];
            ctrl_q.irq_en <= wdata[CTRL_IRQ_EN_B];
            ctrl_q.mode   <= MODE_MAX_W'(wdata[CTRL_MODE_LSB +: MODE_W]);
         end
         done_q <= done_ev | (done_q & ~done_clr);
         ovf_q  <= ovf_set | (ovf_q & ~ovf_clr);
      end
   end

   assign ena      = ctrl_q.ena;
   assign mode     = ctrl_q.mode[MODE_W-1:0];
   assign irq_term = done_q & ctrl_q.irq_en;

   always_comb begin
      ctrl_rd                               = '0;
      ctrl_rd[CTRL_ENA_B]                   = ctrl_q.ena;
      ctrl_rd[CTRL_IRQ_EN_B]                = ctrl_q.irq_en;
      ctrl_rd[CTRL_MODE_LSB +: MODE_MAX_W]  = ctrl_q.mode;
   end

   always_comb begin
      stat_rd              = '0;
      stat_rd[STAT_BUSY_B] = busy;
      stat_rd[STAT_DONE_B] = done_q;
      stat_rd[STAT_OVF_B]  = ovf_q;
   end

   assign unused_wdata = ^{wdata[31:CTRL_MODE_LSB+MODE_W], wdata[3]};

endmodule

// File: rtl/chan_regf.sv
// Multi-channel register file: bus decode, registered read/error responses, aggregated irq.
module chan_regf
   import chan_regf_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int MODE_W = 3,
   parameter int ADDR_W = 13
) (
   input  logic                     main_clk_i,
   input  logic                     main_rst_i,
   input  logic                     soft_rst_i,
   input  logic                     mem_ena_i,
   input  logic [ADDR_W-1:0]        mem_addr_i,
   input  logic                     mem_wena_i,
   input  logic [31:0]              mem_wdata_i,
   output logic [31:0]              mem_rdata_o,
   output logic                     mem_rvld_o,
   output logic                     mem_err_o,
   output logic [NUM_CH-1:0]        regf_ena_o,
   output logic [NUM_CH*MODE_W-1:0] regf_mode_o,
   input  logic [NUM_CH-1:0]        regf_busy_i,
   input  logic [NUM_CH-1:0]        regf_done_i,
   output logic                     irq_o
);

   localparam int NUM_WORDS = 2 * NUM_CH;

   logic                          mapped, rd_req, wr_req;
   logic [NUM_CH-1:0][31:0]       ctrl_rd, stat_rd;
   logic [NUM_CH-1:0]             irq_term;
   logic [31:0]                   rd_word;

   assign mapped = mem_addr_i < ADDR_W'(NUM_WORDS);
   assign rd_req = mem_ena_i & ~mem_wena_i;
   assign wr_req = mem_ena_i & mem_wena_i & mapped;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         logic ctrl_we, stat_we;

         assign ctrl_we = wr_req & (mem_addr_i == ADDR_W'(word_addr(c, 1'b0)));
         assign stat_we = wr_req & (mem_addr_i == ADDR_W'(word_addr(c, 1'b1)));

         chan_regf_ch #(.MODE_W(MODE_W)) u_ch (
            .main_clk_i (main_clk_i),
            .main_rst_i (main_rst_i),
            .soft_rst_i (soft_rst_i),
            .ctrl_we    (ctrl_we),
            .stat_we    (stat_we),
            .wdata      (mem_wdata_i),
            .busy       (regf_busy_i[c]),
            .done_ev    (regf_done_i[c]),
            .ena        (regf_ena_o[c]),
            .mode       (regf_mode_o[c*MODE_W +: MODE_W]),
            .irq_term   (irq_term[c]),
            .ctrl_rd    (ctrl_rd[c]),
            .stat_rd    (stat_rd[c])
         );
      end
   endgenerate

   // Read mux sees pre-edge channel state, so a same-cycle done event is not yet visible.
   always_comb begin
      rd_word = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (mem_addr_i == ADDR_W'(word_addr(c, 1'b0))) rd_word = ctrl_rd[c];
         if (mem_addr_i == ADDR_W'(word_addr(c, 1'b1))) rd_word = stat_rd[c];
      end
   end

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i || soft_rst_i) begin
         mem_rdata_o <= '0;
         mem_rvld_o  <= 1'b0;
         mem_err_o   <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         mem_rvld_o  <= rd_req;
         mem_err_o   <= mem_ena_i & ~mapped;
         mem_rdata_o <= (rd_req && mapped) ? rd_word : '0;
         irq_o       <= |irq_term;
      end
   end

endmodule

// File: tb/tb_chan_regf.sv
// Scoreboard bench for chan_regf: responses checked against a spec-level model of the register map.
module tb_chan_regf;

   localparam int NUM_CH = 4;
   localparam int MODE_W = 3;
   localparam int ADDR_W = 13;
   localparam int NW     = 2 * NUM_CH;
   localparam logic [31:0] CTRL_MASK = 32'h3 | (((32'd1 << MODE_W) - 32'd1) << 4);

   logic                     main_clk_i, main_rst_i, soft_rst_i;
   logic                     mem_ena_i, mem_wena_i;
   logic [ADDR_W-1:0]        mem_addr_i;
   logic [31:0]              mem_wdata_i, mem_rdata_o;
   logic                     mem_rvld_o, mem_err_o, irq_o;
   logic [NUM_CH-1:0]        regf_ena_o, regf_busy_i, regf_done_i;
   logic [NUM_CH*MODE_W-1:0] regf_mode_o;

   chan_regf #(.NUM_CH(NUM_CH), .MODE_W(MODE_W), .ADDR_W(ADDR_W)) dut (
      .main_clk_i  (main_clk_i),
      .main_rst_i  (main_rst_i),
      .soft_rst_i  (soft_rst_i),
      .mem_ena_i   (mem_ena_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wena_i  (mem_wena_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdata_o (mem_rdata_o),
      .mem_rvld_o  (mem_rvld_o),
      .mem_err_o   (mem_err_o),
      .regf_ena_o  (regf_ena_o),
      .regf_mode_o (regf_mode_o),
      .regf_busy_i (regf_busy_i),
      .regf_done_i (regf_done_i),
      .irq_o       (irq_o)
   );

   initial main_clk_i = 1'b0;
   always #5 main_clk_i = ~main_clk_i;

   typedef struct {
      logic        is_rd;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t              sb[$];
   exp_t              e;
   int                n_cmp = 0;
   int                n_err = 0;
   logic [31:0]       ctrl_m [NUM_CH];
   logic [NUM_CH-1:0] done_m, ovf_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_rd(input int a);
      int c;
      c = a / 2;
      if (a % 2 == 0) return ctrl_m[c];
      return {29'd0, ovf_m[c], done_m[c], regf_busy_i[c]};
   endfunction

   function automatic logic irq_model();
      logic r;
      r = 1'b0;
      for (int c = 0; c < NUM_CH; c++) r |= done_m[c] & ctrl_m[c][1];
      return r;
   endfunction

   function automatic logic [31:0] ena_model();
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < NUM_CH; c++) r[c] = ctrl_m[c][0];
      return r;
   endfunction

   function automatic logic [31:0] mode_model();
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < NUM_CH; c++) r[c*MODE_W +: MODE_W] = ctrl_m[c][4 +: MODE_W];
      return r;
   endfunction

   // One bus cycle plus optional done events; expectations pushed, model advanced.
   task automatic cyc(input logic en, input logic we, input int a, input logic [31:0] wd,
                      input logic [NUM_CH-1:0] dn);
      logic [NUM_CH-1:0] clr_d, clr_o;
      logic mp;
      @(negedge main_clk_i);
      mem_ena_i   = en;
      mem_wena_i  = we;
      mem_addr_i  = ADDR_W'(a);
      mem_wdata_i = wd;
      regf_done_i = dn;
      mp    = (a < NW);
      clr_d = '0;
      clr_o = '0;
      if (en && !we) sb.push_back('{1'b1, !mp, mp ? model_rd(a) : 32'd0});
      if (en && we && !mp) sb.push_back('{1'b0, 1'b1, 32'd0});
      if (en && we && mp) begin
         if (a % 2 == 0) ctrl_m[a/2] = wd & CTRL_MASK;
         else begin
            clr_d[a/2] = wd[1];
            clr_o[a/2] = wd[2];
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (dn[c]) begin
            if (done_m[c] && !clr_d[c]) ovf_m[c] = 1'b1;
            else if (clr_o[c]) ovf_m[c] = 1'b0;
            done_m[c] = 1'b1;
         end else begin
            if (clr_o[c]) ovf_m[c] = 1'b0;
            if (clr_d[c]) done_m[c] = 1'b0;
         end
      end
      @(posedge main_clk_i); #1;
      mem_ena_i   = 1'b0;
      mem_wena_i  = 1'b0;
      regf_done_i = '0;
   endtask

   task automatic rd(input int a);                     cyc(1'b1, 1'b0, a, 32'd0, '0); endtask
   task automatic wr(input int a, input logic [31:0] d); cyc(1'b1, 1'b1, a, d, '0);    endtask
   task automatic pulse(input logic [NUM_CH-1:0] m);    cyc(1'b0, 1'b0, 0, 32'd0, m);  endtask
   task automatic idle();                              cyc(1'b0, 1'b0, 0, 32'd0, '0); endtask

   always @(negedge main_clk_i) begin
      if (mem_rvld_o || mem_err_o) begin
         if (sb.size() == 0) chk("spurious_rsp", {30'd0, mem_rvld_o, mem_err_o}, 32'd0);
         else begin
            e = sb.pop_front();
            chk("rvld", 32'(mem_rvld_o), 32'(e.is_rd));
            chk("err", 32'(mem_err_o), 32'(e.err));
            chk("rdata", mem_rdata_o, e.data);
         end
      end
   end

   initial begin
      main_rst_i  = 1'b1;
      soft_rst_i  = 1'b0;
      mem_ena_i   = 1'b0;
      mem_wena_i  = 1'b0;
      mem_addr_i  = '0;
      mem_wdata_i = '0;
      regf_busy_i = 4'b1010;
      regf_done_i = '0;
      done_m      = '0;
      ovf_m       = '0;
      for (int c = 0; c < NUM_CH; c++) ctrl_m[c] = '0;
      repeat (3) @(posedge main_clk_i);
      #1 main_rst_i = 1'b0;

      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_rvld", 32'(mem_rvld_o), 32'd0);
      chk("rst_err", 32'(mem_err_o), 32'd0);
      chk("rst_ena", 32'(regf_ena_o), ena_model());
      chk("rst_mode", 32'(regf_mode_o), mode_model());
      for (int a = 0; a < NW; a++) rd(a);

      // Control writes, including write-ones to reserved bits.
      wr(4, 32'h0000_0073);
      chk("ena_vec", 32'(regf_ena_o), ena_model());
      chk("mode_vec", 32'(regf_mode_o), mode_model());
      rd(4);
      wr(6, 32'hFFFF_FF8C);
      rd(6);

      // Done twice with irq enabled -> overflow and irq; W1C clears both.
      wr(2, 32'h2);
      pulse(4'b0010);
      idle();
      chk("irq_done", 32'(irq_o), 32'(irq_model()));
      pulse(4'b0010);
      rd(3);
      wr(3, 32'h6);
      chk("irq_hold", 32'(irq_o), 32'd1);
      idle();
      chk("irq_clr", 32'(irq_o), 32'(irq_model()));
      rd(3);

      // irq_en cleared with done still set.
      pulse(4'b0010);
      idle();
      chk("irq_set2", 32'(irq_o), 32'(irq_model()));
      wr(2, 32'h0);
      idle();
      chk("irq_en_off", 32'(irq_o), 32'(irq_model()));
      rd(3);

      // Event coincident with W1C of an already-set done: set wins, no overflow.
      pulse(4'b0001);
      cyc(1'b1, 1'b1, 1, 32'h2, 4'b0001);
      rd(1);

      // Read coincident with an event returns the pre-update value.
      cyc(1'b1, 1'b0, 5, 32'd0, 4'b0100);
      rd(5);
      regf_busy_i = 4'b0101;
      rd(1);
      rd(3);

      // Unmapped accesses.
      rd(NW);
      wr(NW, 32'hFFFF_FFFF);
      rd(13'h1FFF);
      for (int c = 0; c < NUM_CH; c++) rd(2*c);
      chk("err_ena", 32'(regf_ena_o), ena_model());
      chk("err_mode", 32'(regf_mode_o), mode_model());

      // Soft reset with a read in flight.
      for (int c = 0; c < NUM_CH; c++) wr(2*c, 32'hFF);
      pulse(4'b1111);
      idle();
      chk("irq_pre_soft", 32'(irq_o), 32'(irq_model()));
      @(negedge main_clk_i);
      soft_rst_i = 1'b1;
      mem_ena_i  = 1'b1;
      mem_wena_i = 1'b0;
      mem_addr_i = ADDR_W'(1);
      @(posedge main_clk_i); #1;
      soft_rst_i = 1'b0;
      mem_ena_i  = 1'b0;
      done_m = '0;
      ovf_m  = '0;
      for (int c = 0; c < NUM_CH; c++) ctrl_m[c] = '0;
      @(negedge main_clk_i);
      chk("soft_rvld", 32'(mem_rvld_o), 32'd0);
      chk("soft_irq", 32'(irq_o), 32'(irq_model()));
      chk("soft_ena", 32'(regf_ena_o), ena_model());
      chk("soft_mode", 32'(regf_mode_o), mode_model());
      for (int a = 0; a < NW; a++) rd(a);

      idle();
      idle();
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
